// File: rtl/logic_thief_ctrl.sv
// Capture sequencer for the logic-thief trace BRAM: circular pre-trigger capture,
// masked trigger on the probed ctrl byte, programmable post-trigger run, then stop.
module logic_thief_ctrl #(
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter int unsigned CTRL_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [31:0]           cmd_i,
    input  logic [CTRL_WIDTH-1:0] probe_ctrl_i,
    input  logic [CTRL_WIDTH-1:0] trig_val_i,
    input  logic [CTRL_WIDTH-1:0] trig_mask_i,
    input  logic [DEPTH_LOG2-1:0] post_count_i,
    output logic [DEPTH_LOG2-1:0] wr_addr_o,
    output logic                  wr_en_o,
    output logic [DEPTH_LOG2-1:0] trig_addr_o,
    output logic                  wrapped_o,
    output logic [1:0]            state_o,
    output logic                  done_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        CAPTURE = 2'b01,
        POST    = 2'b10,
        DONE    = 2'b11
    } state_t;

    localparam logic [31:0] CMD_CLEAR = 32'hDEADDEAD;
    localparam logic [31:0] CMD_ARM   = 32'hDEADCAFE;
    localparam logic [31:0] CMD_FORCE = 32'hDEADBEEF;

    state_t                state_q, state_d;
    logic [31:0]           cmd_q;
    logic [DEPTH_LOG2-1:0] ptr_q, ptr_d;
    logic [DEPTH_LOG2-1:0] trig_q, trig_d;
    logic [DEPTH_LOG2-1:0] cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] post_q, post_d;
    logic                  wrapped_q, wrapped_d;

    logic cmd_fire, is_clear, is_arm, is_force, match;

    always_comb begin
        cmd_fire = (cmd_i != cmd_q);
        is_clear = cmd_fire && (cmd_i == CMD_CLEAR);
        is_arm   = cmd_fire && (cmd_i == CMD_ARM);
        is_force = cmd_fire && (cmd_i == CMD_FORCE);
        match    = (((probe_ctrl_i ^ trig_val_i) & trig_mask_i) == '0);
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        trig_d    = trig_q;
        cnt_d     = cnt_q;
        post_d    = post_q;
        wrapped_d = wrapped_q;
        if (is_clear) begin
            state_d   = IDLE;
            ptr_d     = '0;
            trig_d    = '0;
            wrapped_d = 1'b0;
            cnt_d     = '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (is_arm) begin
                        state_d   = CAPTURE;
                        ptr_d     = '0;
                        wrapped_d = 1'b0;
                        post_d    = post_count_i;
                    end
                end
                CAPTURE: begin
                    ptr_d = ptr_q + 1'b1;
                    if (ptr_q == '1) wrapped_d = 1'b1;
                    if (match || is_force) begin
                        trig_d = ptr_q;
                        if (post_q == '0) begin
                            state_d = DONE;
                        end else begin
                            state_d = POST;
                            cnt_d   = post_q;
                        end
                    end
                end
                POST: begin
                    // Wrap is tracked here too so "oldest = ptr when wrapped" holds after post writes wrap.
                    ptr_d = ptr_q + 1'b1;
                    if (ptr_q == '1) wrapped_d = 1'b1;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == DEPTH_LOG2'(1)) state_d = DONE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        cmd_q <= cmd_i;
        if (reset_i) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            trig_q    <= '0;
            cnt_q     <= '0;
            post_q    <= '0;
            wrapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            trig_q    <= trig_d;
            cnt_q     <= cnt_d;
            post_q    <= post_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign wr_en_o     = (state_q == CAPTURE) || (state_q == POST);
    assign wr_addr_o   = ptr_q;
    assign trig_addr_o = trig_q;
    assign wrapped_o   = wrapped_q;
    assign state_o     = state_q;
    assign done_o      = (state_q == DONE);

endmodule

// File: tb/tb_logic_thief_ctrl.sv
// Self-checking bench for logic_thief_ctrl: behavioural capture model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_logic_thief_ctrl;

    localparam logic [31:0] CLR = 32'hDEADDEAD;
    localparam logic [31:0] ARM = 32'hDEADCAFE;
    localparam logic [31:0] FRC = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [31:0] cmd;
    logic [7:0]  probe, tval, tmask, post;
    logic [7:0]  wr_addr, trig_addr;
    logic        wr_en, wrapped, done;
    logic [1:0]  state;

    always #5 clk = ~clk;

    logic_thief_ctrl #(.DEPTH_LOG2(8), .CTRL_WIDTH(8)) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .cmd_i        (cmd),
        .probe_ctrl_i (probe),
        .trig_val_i   (tval),
        .trig_mask_i  (tmask),
        .post_count_i (post),
        .wr_addr_o    (wr_addr),
        .wr_en_o      (wr_en),
        .trig_addr_o  (trig_addr),
        .wrapped_o    (wrapped),
        .state_o      (state),
        .done_o       (done)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int dut_writes = 0;
    int dut_addr0  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase, write count-driven address, remaining post writes.
    typedef enum {M_IDLE, M_CAP, M_POST, M_DONE} mph_t;
    mph_t        m_ph = M_IDLE;
    int          m_addr = 0, m_trig = 0, m_post = 0, m_left = 0;
    bit          m_wrapped = 1'b0, m_valid = 1'b0, m_fired;
    logic [31:0] m_cmd_prev;
    int          m_hist [256];

    function automatic bit trig_hit(input logic [7:0] p, input logic [7:0] v, input logic [7:0] m);
        for (int b = 0; b < 8; b++)
            if (m[b] && (p[b] != v[b])) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [1:0] ph_code(input mph_t p);
        case (p)
            M_CAP:   return 2'b01;
            M_POST:  return 2'b10;
            M_DONE:  return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset_i) begin
            m_ph = M_IDLE; m_addr = 0; m_trig = 0; m_wrapped = 1'b0; m_left = 0;
            m_cmd_prev = cmd; m_valid = 1'b1;
        end else begin
            m_fired = (cmd != m_cmd_prev);
            m_cmd_prev = cmd;
            if (m_fired && cmd == CLR) begin
                m_ph = M_IDLE; m_addr = 0; m_trig = 0; m_wrapped = 1'b0;
            end else begin
                if (m_ph == M_CAP || m_ph == M_POST) begin
                    m_hist[m_addr]++;
                    if (m_addr == 255) m_wrapped = 1'b1;
                end
                case (m_ph)
                    M_IDLE, M_DONE: if (m_fired && cmd == ARM) begin
                        m_ph = M_CAP; m_addr = 0; m_wrapped = 1'b0; m_post = int'(post);
                        foreach (m_hist[i]) m_hist[i] = 0;
                    end
                    M_CAP: begin
                        if (trig_hit(probe, tval, tmask) || (m_fired && cmd == FRC)) begin
                            m_trig = m_addr;
                            m_left = m_post;
                            m_ph = (m_left == 0) ? M_DONE : M_POST;
                        end
                        m_addr = (m_addr + 1) % 256;
                    end
                    M_POST: begin
                        m_left--;
                        m_addr = (m_addr + 1) % 256;
                        if (m_left == 0) m_ph = M_DONE;
                    end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("wr_addr",   wr_addr,   m_addr);
            chk("wr_en",     wr_en,     (m_ph == M_CAP || m_ph == M_POST));
            chk("trig_addr", trig_addr, m_trig);
            chk("wrapped",   wrapped,   m_wrapped);
            chk("state",     state,     ph_code(m_ph));
            chk("done",      done,      (m_ph == M_DONE));
            if (wr_en === 1'b1) begin
                dut_writes++;
                if (wr_addr == 8'd0) dut_addr0++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_addr(input logic [7:0] a, input string nm);
        int k;
        k = 0;
        while (!(wr_addr === a && wr_en === 1'b1) && k < 2000) begin
            tick(1);
            k++;
        end
        chk(nm, (k < 2000), 1);
    endtask

    task automatic wait_done(input string nm);
        int k;
        k = 0;
        while (done !== 1'b1 && k < 2000) begin
            tick(1);
            k++;
        end
        chk(nm, (k < 2000), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        reset_i = 1'b1; cmd = '0; probe = 8'h00; tval = 8'hFF; tmask = 8'hFF; post = 8'd4;
        tick(3);
        reset_i = 1'b0;
        tick(1);
        chk("rst_state", state, 2'b00);
        chk("rst_addr", wr_addr, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_trig", trig_addr, 0);
        chk("rst_wrapped", wrapped, 0);

        // 1: trigger at capture cycle 10, post=4
        dut_writes = 0;
        cmd = ARM;
        wait_addr(8'd10, "t1_reach10");
        probe = 8'hFF;
        tick(1);
        probe = 8'h00;
        wait_done("t1_done");
        chk("t1_trig", trig_addr, 10);
        chk("t1_addr", wr_addr, 15);
        chk("t1_wr_en", wr_en, 0);
        chk("t1_writes", dut_writes, 15);
        chk("t1_model_trig", m_trig, 10);

        // 2: held ARM does not re-arm; CLEAR then ARM does
        tick(50);
        chk("t2_state_held", state, 2'b11);
        chk("t2_writes_held", dut_writes, 15);
        post = 8'd0;
        cmd = CLR;
        tick(1);
        chk("t2_clr_state", state, 2'b00);
        chk("t2_clr_trig", trig_addr, 0);
        chk("t2_clr_addr", wr_addr, 0);
        cmd = ARM;
        tick(1);
        chk("t2_arm_state", state, 2'b01);
        chk("t2_arm_addr", wr_addr, 0);

        // 3: 300 cycles of no trigger, wrap, then FORCE with post=0
        wait_addr(8'd255, "t3_reach255");
        chk("t3_wrapped_pre", wrapped, 0);
        tick(1);
        chk("t3_wrap_addr", wr_addr, 0);
        chk("t3_wrapped_post", wrapped, 1);
        tick(44);
        chk("t3_addr300", wr_addr, 44);
        cmd = FRC;
        tick(1);
        chk("t3_done", done, 1);
        chk("t3_trig", trig_addr, 44);
        chk("t3_addr", wr_addr, 45);

        // 4: mask=0, post=255 fills the ring exactly once
        tmask = 8'h00; post = 8'd255;
        cmd = CLR;
        tick(1);
        dut_writes = 0; dut_addr0 = 0;
        cmd = ARM;
        tick(1);
        wait_done("t4_done");
        chk("t4_writes", dut_writes, 256);
        chk("t4_addr0_once", dut_addr0, 1);
        chk("t4_trig", trig_addr, 0);
        chk("t4_addr", wr_addr, 0);
        chk("t4_model_hist0", m_hist[0], 1);

        // 5: reset during POST with ARM held
        post = 8'd20;
        cmd = CLR;
        tick(1);
        cmd = ARM;
        tick(8);
        chk("t5_in_post", state, 2'b10);
        reset_i = 1'b1;
        tick(1);
        reset_i = 1'b0;
        chk("t5_state", state, 2'b00);
        chk("t5_wr_en", wr_en, 0);
        chk("t5_addr", wr_addr, 0);
        chk("t5_trig", trig_addr, 0);
        chk("t5_done", done, 0);
        dut_writes = 0;
        tick(10);
        chk("t5_no_rearm", state, 2'b00);
        chk("t5_no_writes", dut_writes, 0);

        // 6: mask=0F val=03; 02 misses, F3 hits, matches in POST ignored
        tmask = 8'h0F; tval = 8'h03; probe = 8'h02; post = 8'd3;
        cmd = CLR;
        tick(1);
        cmd = ARM;
        tick(1);
        wait_addr(8'd5, "t6_reach5");
        chk("t6_no_trig_state", state, 2'b01);
        probe = 8'hF3;
        tick(1);
        chk("t6_post_state", state, 2'b10);
        wait_done("t6_done");
        chk("t6_trig", trig_addr, 5);
        chk("t6_addr", wr_addr, 9);
        probe = 8'h00;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
